// File: rtl/bnn_mlp_ctrl.sv
// ---------------------------------------------------------------------------
// bnn_mlp_ctrl
// Sequencing controller for a 4-neuron binary MLP layer. It collects a
// 5-byte inference frame, applies weights/bias/input to the layer from
// registers, raises a scope trigger while the layer settles, then samples
// the 4-bit layer result and offers it on an output stream.
//
// Ports
//   clk, rst_n        system clock (rising edge), async active-low reset
//   abort             synchronous clear of any partial frame / pending result
//   in_valid/in_ready/in_data     input byte stream
//   out_valid/out_ready/out_data  result stream (bit n = neuron n)
//   bnn_weights, bnn_bias, bnn_input  buses driven into the layer
//   bnn_result        combinational layer output
//   trig              high only while the applied frame is evaluating
//   infer_count       completed inferences, saturating
//   dbg_state         current FSM state (IDLE=0, LOAD=1, SETTLE=2, DONE=3)
//
// Handshake: a transfer happens on a rising edge where valid && ready are
// both high. A producer holds valid and data stable until that edge; ready
// may change freely and never depends on valid.
// ---------------------------------------------------------------------------
module bnn_mlp_ctrl #(
    parameter int unsigned SETTLE_CYCLES = 2  // legal range 1..255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        abort,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  in_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [3:0]  out_data,
    output logic [15:0] bnn_weights,
    output logic [15:0] bnn_bias,
    output logic [3:0]  bnn_input,
    input  logic [3:0]  bnn_result,
    output logic        trig,
    output logic [15:0] infer_count,
    output logic [1:0]  dbg_state
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] LOAD   = 2'd1;
    localparam logic [1:0] SETTLE = 2'd2;
    localparam logic [1:0] DONE   = 2'd3;

    localparam logic [7:0] SETTLE_LOAD = 8'(SETTLE_CYCLES - 1);

    logic [1:0]  state_q, state_d;
    logic [2:0]  byte_cnt_q, byte_cnt_d;
    logic [7:0]  settle_cnt_q, settle_cnt_d;
    logic [15:0] w_sh_q, w_sh_d;
    logic [15:0] b_sh_q, b_sh_d;
    logic [15:0] weights_q, weights_d;
    logic [15:0] bias_q, bias_d;
    logic [3:0]  input_q, input_d;
    logic [3:0]  out_data_q, out_data_d;
    logic        out_valid_q, out_valid_d;
    logic        trig_q, trig_d;
    logic [15:0] infer_count_q, infer_count_d;
    logic        accept;

    assign in_ready = (state_q == IDLE) || (state_q == LOAD);
    assign accept   = in_valid && in_ready;

    always_comb begin
        state_d       = state_q;
        byte_cnt_d    = byte_cnt_q;
        settle_cnt_d  = settle_cnt_q;
        w_sh_d        = w_sh_q;
        b_sh_d        = b_sh_q;
        weights_d     = weights_q;
        bias_d        = bias_q;
        input_d       = input_q;
        out_data_d    = out_data_q;
        out_valid_d   = out_valid_q;
        trig_d        = trig_q;
        infer_count_d = infer_count_q;

        if (abort) begin
            // Abort wins over everything, including a byte offered this cycle.
            state_d     = IDLE;
            byte_cnt_d  = 3'd0;
            out_valid_d = 1'b0;
            trig_d      = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        w_sh_d[15:8] = in_data;
                        byte_cnt_d   = 3'd1;
                        state_d      = LOAD;
                    end
                end
                LOAD: begin
                    if (accept) begin
                        byte_cnt_d = byte_cnt_q + 3'd1;
                        case (byte_cnt_q)
                            3'd1:    w_sh_d[7:0]  = in_data;
                            3'd2:    b_sh_d[15:8] = in_data;
                            3'd3:    b_sh_d[7:0]  = in_data;
                            default: begin
                                // Last byte: all layer buses switch together on
                                // this edge so the layer never sees a mixed frame.
                                weights_d    = w_sh_q;
                                bias_d       = b_sh_q;
                                input_d      = in_data[3:0];
                                byte_cnt_d   = 3'd0;
                                settle_cnt_d = SETTLE_LOAD;
                                trig_d       = 1'b1;
                                state_d      = SETTLE;
                            end
                        endcase
                    end
                end
                SETTLE: begin
                    if (settle_cnt_q == 8'd0) begin
                        out_data_d  = bnn_result;
                        trig_d      = 1'b0;
                        out_valid_d = 1'b1;
                        if (infer_count_q != 16'hFFFF) begin
                            infer_count_d = infer_count_q + 16'd1;
                        end
                        state_d = DONE;
                    end else begin
                        settle_cnt_d = settle_cnt_q - 8'd1;
                    end
                end
                default: begin  // DONE
                    if (out_valid_q && out_ready) begin
                        out_valid_d = 1'b0;
                        state_d     = IDLE;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            byte_cnt_q    <= 3'd0;
            settle_cnt_q  <= 8'd0;
            w_sh_q        <= 16'd0;
            b_sh_q        <= 16'd0;
            weights_q     <= 16'd0;
            bias_q        <= 16'd0;
            input_q       <= 4'd0;
            out_data_q    <= 4'd0;
            out_valid_q   <= 1'b0;
            trig_q        <= 1'b0;
            infer_count_q <= 16'd0;
        end else begin
            state_q       <= state_d;
            byte_cnt_q    <= byte_cnt_d;
            settle_cnt_q  <= settle_cnt_d;
            w_sh_q        <= w_sh_d;
            b_sh_q        <= b_sh_d;
            weights_q     <= weights_d;
            bias_q        <= bias_d;
            input_q       <= input_d;
            out_data_q    <= out_data_d;
            out_valid_q   <= out_valid_d;
            trig_q        <= trig_d;
            infer_count_q <= infer_count_d;
        end
    end

    assign out_valid   = out_valid_q;
    assign out_data    = out_data_q;
    assign bnn_weights = weights_q;
    assign bnn_bias    = bias_q;
    assign bnn_input   = input_q;
    assign trig        = trig_q;
    assign infer_count = infer_count_q;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_bnn_mlp_ctrl.sv
// ---------------------------------------------------------------------------
// tb_bnn_mlp_ctrl
// Three controllers with SETTLE_CYCLES = 2, 1 and 255 share one clock and
// reset. A frame-level reference model (expected bus values, expected
// result queue, inference count) predicts every observed output.
// ---------------------------------------------------------------------------
module tb_bnn_mlp_ctrl;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    logic        abort       [3];
    logic        in_valid    [3];
    logic        in_ready    [3];
    logic [7:0]  in_data     [3];
    logic        out_valid   [3];
    logic        out_ready   [3];
    logic [3:0]  out_data    [3];
    logic [15:0] bnn_weights [3];
    logic [15:0] bnn_bias    [3];
    logic [3:0]  bnn_input   [3];
    logic [3:0]  bnn_result  [3];
    logic        trig        [3];
    logic [15:0] infer_count [3];
    logic [1:0]  dbg_state   [3];

    for (genvar gi = 0; gi < 3; gi++) begin : g_dut
        bnn_mlp_ctrl #(
            .SETTLE_CYCLES((gi == 0) ? 2 : (gi == 1) ? 1 : 255)
        ) u_dut (
            .clk         (clk),
            .rst_n       (rst_n),
            .abort       (abort[gi]),
            .in_valid    (in_valid[gi]),
            .in_ready    (in_ready[gi]),
            .in_data     (in_data[gi]),
            .out_valid   (out_valid[gi]),
            .out_ready   (out_ready[gi]),
            .out_data    (out_data[gi]),
            .bnn_weights (bnn_weights[gi]),
            .bnn_bias    (bnn_bias[gi]),
            .bnn_input   (bnn_input[gi]),
            .bnn_result  (bnn_result[gi]),
            .trig        (trig[gi]),
            .infer_count (infer_count[gi]),
            .dbg_state   (dbg_state[gi])
        );
    end

    // ---------------- reference model / scoreboard ----------------
    int          s_of  [3] = '{2, 1, 255};
    logic [15:0] m_w   [3];
    logic [15:0] m_b   [3];
    logic [3:0]  m_i   [3];
    logic [3:0]  m_out [3];
    logic [15:0] m_cnt [3];
    logic [3:0]  exp_q [$];
    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            m_w[k] = '0; m_b[k] = '0; m_i[k] = '0; m_out[k] = '0; m_cnt[k] = '0;
        end
        exp_q.delete();
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic check_reset_outputs(input int k);
        check("rst_in_ready",  in_ready[k],    1);
        check("rst_out_valid", out_valid[k],   0);
        check("rst_out_data",  out_data[k],    0);
        check("rst_trig",      trig[k],        0);
        check("rst_weights",   bnn_weights[k], 0);
        check("rst_bias",      bnn_bias[k],    0);
        check("rst_input",     bnn_input[k],   0);
        check("rst_count",     infer_count[k], 0);
    endtask

    task automatic check_held(input int k, input string tag);
        check({tag, "_w"},    bnn_weights[k], m_w[k]);
        check({tag, "_b"},    bnn_bias[k],    m_b[k]);
        check({tag, "_i"},    bnn_input[k],   m_i[k]);
        check({tag, "_trig"}, trig[k],        0);
    endtask

    // ---------------- driver tasks ----------------
    // Push the first n bytes of a frame (byte 0 in fr[39:32]).
    task automatic push_bytes(input int k, input logic [39:0] fr, input int n, input bit gaps);
        for (int j = 0; j < n; j++) begin
            if (gaps) begin
                int gap = $urandom_range(0, 3);
                in_valid[k] = 1'b0;
                for (int x = 0; x < gap; x++) begin
                    tick();
                    check_held(k, "gap_hold");
                end
            end
            in_valid[k] = 1'b1;
            in_data[k]  = fr[39 - 8*j -: 8];
            check("in_ready_load", in_ready[k], 1);
            tick();
            if (j < 4) check_held(k, "midframe_hold");
        end
        in_valid[k] = 1'b0;
    endtask

    // Full frame up to out_valid; the result is left pending.
    task automatic run_frame(input int k, input logic [39:0] fr, input logic [3:0] res, input bit gaps);
        int width;
        logic [3:0] exp_r;
        bnn_result[k] = res;
        push_bytes(k, fr, 5, gaps);
        m_w[k] = fr[39:24];
        m_b[k] = fr[23:8];
        m_i[k] = fr[3:0];
        exp_q.push_back(res);
        check("commit_w",     bnn_weights[k], m_w[k]);
        check("commit_b",     bnn_bias[k],    m_b[k]);
        check("commit_i",     bnn_input[k],   m_i[k]);
        check("commit_trig",  trig[k],        1);
        check("settle_ready", in_ready[k],    0);
        width = 0;
        while (trig[k] === 1'b1 && width < 300) begin
            width++;
            tick();
        end
        check("trig_width", width, s_of[k]);
        check("result_valid", out_valid[k], 1);
        exp_r = (exp_q.size() > 0) ? exp_q.pop_front() : 4'hx;
        m_out[k] = exp_r;
        check("result_data", out_data[k], exp_r);
        if (m_cnt[k] != 16'hFFFF) m_cnt[k] = m_cnt[k] + 16'd1;
        check("infer_count", infer_count[k], m_cnt[k]);
    endtask

    // Hold off the consumer for 'hold' cycles (a stray byte is offered in
    // the middle), then complete the result handshake.
    task automatic release_result(input int k, input int hold);
        out_ready[k] = 1'b0;
        for (int x = 0; x < hold; x++) begin
            if (x == hold / 2) begin
                in_valid[k] = 1'b1;
                in_data[k]  = 8'hEE;
            end
            tick();
            check("bp_valid", out_valid[k], 1);
            check("bp_data",  out_data[k],  m_out[k]);
            check("bp_ready", in_ready[k],  0);
        end
        in_valid[k]  = 1'b0;
        out_ready[k] = 1'b1;
        tick();
        out_ready[k] = 1'b0;
        check("hs_valid_drop", out_valid[k],   0);
        check("hs_in_ready",   in_ready[k],    1);
        check("hs_count",      infer_count[k], m_cnt[k]);
    endtask

    // Three frames with in_valid and out_ready held high; checks frame period.
    task automatic back_to_back(input int k);
        int start[3];
        int t;
        logic [39:0] fr;
        logic [3:0]  res;
        out_ready[k] = 1'b1;
        for (int f = 0; f < 3; f++) begin
            fr  = {$urandom, $urandom} & 40'hFF_FFFF_FFFF;
            res = 4'($urandom_range(0, 15));
            for (int j = 0; j < 5; j++) begin
                in_valid[k] = 1'b1;
                in_data[k]  = fr[39 - 8*j -: 8];
                t = 0;
                while (in_ready[k] !== 1'b1 && t < 400) begin
                    t++;
                    tick();
                end
                if (t >= 400) check("b2b_ready_timeout", 1, 0);
                if (j == 0) begin
                    start[f] = cyc;
                    if (f > 0) check("b2b_valid_one_cycle", out_valid[k], 0);
                    bnn_result[k] = res;
                end
                tick();
            end
            m_w[k] = fr[39:24]; m_b[k] = fr[23:8]; m_i[k] = fr[3:0];
            check("b2b_commit_w", bnn_weights[k], m_w[k]);
            t = 0;
            while (out_valid[k] !== 1'b1 && t < 400) begin
                t++;
                tick();
            end
            if (t >= 400) check("b2b_valid_timeout", 1, 0);
            m_out[k] = res;
            if (m_cnt[k] != 16'hFFFF) m_cnt[k] = m_cnt[k] + 16'd1;
            check("b2b_data",  out_data[k],    res);
            check("b2b_count", infer_count[k], m_cnt[k]);
            if (f > 0) check("b2b_period", start[f] - start[f-1], s_of[k] + 6);
        end
        in_valid[k] = 1'b0;
        tick();
        check("b2b_last_hs", out_valid[k], 0);
        out_ready[k] = 1'b0;
    endtask

    // ---------------- main sequence ----------------
    initial begin
        logic [39:0] fr;
        rst_n = 1'b0;
        for (int k = 0; k < 3; k++) begin
            abort[k] = 0; in_valid[k] = 0; in_data[k] = 0;
            out_ready[k] = 0; bnn_result[k] = 0;
        end
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) check_reset_outputs(k);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Directed single frame with 10-cycle backpressure.
        run_frame(0, 40'hA53C0FF009, 4'hB, 1'b0);
        check("single_w",     bnn_weights[0], 16'hA53C);
        check("single_b",     bnn_bias[0],    16'h0FF0);
        check("single_i",     bnn_input[0],   4'h9);
        check("single_out",   out_data[0],    4'hB);
        check("single_count", infer_count[0], 16'd1);
        release_result(0, 10);

        // Random gapped frames.
        for (int n = 0; n < 6; n++) begin
            fr = {$urandom, $urandom} & 40'hFF_FFFF_FFFF;
            run_frame(0, fr, 4'($urandom_range(0, 15)), 1'b1);
            release_result(0, $urandom_range(0, 3));
        end

        // Abort after two bytes, then a clean frame.
        push_bytes(0, 40'hDEADBEEF0A, 2, 1'b0);
        abort[0] = 1'b1; in_valid[0] = 1'b1; in_data[0] = 8'h77;
        check("abort_in_ready", in_ready[0], 1);
        tick();
        abort[0] = 1'b0; in_valid[0] = 1'b0;
        check("abort_idle_ready", in_ready[0], 1);
        check_held(0, "abort_hold");
        run_frame(0, 40'h1122334405, 4'h6, 1'b0);
        check("abort_new_w", bnn_weights[0], 16'h1122);
        check("abort_new_b", bnn_bias[0],    16'h3344);
        check("abort_new_i", bnn_input[0],   4'h5);
        release_result(0, 0);

        // Abort while the result is pending.
        run_frame(0, 40'h5A5AC3C30C, 4'h3, 1'b0);
        abort[0] = 1'b1;
        tick();
        abort[0] = 1'b0;
        check("abort_done_valid", out_valid[0],   0);
        check("abort_done_count", infer_count[0], m_cnt[0]);
        check("abort_done_data",  out_data[0],    m_out[0]);
        check("abort_done_ready", in_ready[0],    1);

        // Async reset in the middle of SETTLE.
        push_bytes(0, 40'h0123456707, 5, 1'b0);
        tick();
        check("pre_reset_trig", trig[0], 1);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        for (int k = 0; k < 3; k++) check_reset_outputs(k);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        run_frame(0, 40'h89ABCDEF0E, 4'h7, 1'b1);
        release_result(0, 1);

        // Boundary settle values and back-to-back throughput.
        for (int k = 0; k < 3; k++) begin
            fr = {$urandom, $urandom} & 40'hFF_FFFF_FFFF;
            run_frame(k, fr, 4'($urandom_range(0, 15)), 1'b0);
            release_result(k, 2);
            back_to_back(k);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/bnn_mlp_ctrl.md
# bnn_mlp_ctrl

Sequencing controller for the 4-neuron binary MLP layer on the CW305 target. It receives a 5-byte inference frame (weights, bias, input) over a byte stream from the SPI front end, and drives the layer's weight, bias and input buses from registers. It raises the capture trigger while the combinational layer settles, then samples the 4-bit result and returns it over an output stream handshake.

## Interface
- SETTLE_CYCLES, 2, cycles the datapath is held stable before the result is sampled; legal range 1..255
- clk  in  1  system clock; all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- abort  in  1  synchronous clear; drops any partial frame or pending result
- in_valid  in  1  frame byte valid
- in_ready  out  1  controller accepts a byte
- in_data  in  8  frame byte
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- out_data  out  4  captured layer result, bit n = neuron n
- bnn_weights  out  16  weight bus to layer; [15:12] neuron0 … [3:0] neuron3
- bnn_bias  out  16  bias bus to layer, same slicing as weights
- bnn_input  out  4  input vector to layer
- bnn_result  in  4  combinational layer output
- trig  out  1  scope trigger, high only while the layer is evaluating the applied frame
- infer_count  out  16  completed inferences, saturates at 16'hFFFF

## Operation
- States: IDLE, LOAD, SETTLE, DONE.
- Frame byte order: 0 = W[15:8], 1 = W[7:0], 2 = B[15:8], 3 = B[7:0], 4 = {ignored[7:4], I[3:0]}.
- A byte is accepted on a cycle with in_valid && in_ready. in_ready = 1 in IDLE and LOAD, 0 in SETTLE and DONE.
- IDLE: the first accepted byte goes to shadow W[15:8], byte_cnt becomes 1, and the state moves to LOAD.
- LOAD: each accepted byte goes to the shadow slot given by byte_cnt, and byte_cnt increments. When byte 4 is accepted, all shadow values are copied to the bnn_* output registers on the same edge, settle_cnt is loaded with SETTLE_CYCLES-1, trig is set, and the state moves to SETTLE.
- bnn_* outputs change only at that commit edge. They never change mid-frame, and they keep their last value in every other state.
- SETTLE: settle_cnt decrements each cycle. On the cycle settle_cnt == 0:
  - bnn_result is sampled into out_data;
  - trig is cleared;
  - out_valid is set;
  - infer_count is incremented (saturating);
  - the state moves to DONE.
- DONE: out_data and out_valid are held until out_valid && out_ready. On that edge out_valid is cleared and the state moves to IDLE.
- abort, in any state, takes priority over all other events on the same edge:
  - state goes to IDLE, byte_cnt to 0, out_valid to 0, trig to 0;
  - bnn_*, out_data and infer_count are unchanged;
  - a byte presented on the abort cycle is not accepted (in_ready is still high, but it is ignored).
- Bytes are never accepted while SETTLE or DONE is active. The upstream must stall.
- Mid-operation reset: all registers return to reset values immediately, independent of clk.

## Timing
- Reset values:
  - in_ready = 1 (state IDLE); the bench must not drive in_valid during reset;
  - out_valid = 0, out_data = 0, trig = 0;
  - bnn_weights = 0, bnn_bias = 0, bnn_input = 0;
  - infer_count = 0.
- Let byte 4 be accepted at edge E:
  - bnn_* and trig = 1 are visible after E;
  - trig stays high for exactly SETTLE_CYCLES cycles;
  - bnn_result is sampled at edge E + SETTLE_CYCLES;
  - out_valid = 1 and trig = 0 after that same edge.
- Latency from the last byte accepted to out_valid is SETTLE_CYCLES cycles. With out_ready held high, out_valid is high for exactly 1 cycle.
- A new frame can start on the cycle after the result handshake. Back-to-back frame period is 5 + SETTLE_CYCLES + 1 cycles with continuous in_valid and out_ready.
- byte_cnt is 3 bits; settle_cnt is 8 bits. No wrap is possible because byte_cnt is reset on commit.

## Test plan
- Single frame, SETTLE_CYCLES = 2. Send bytes A5, 3C, 0F, F0, 09 with bnn_result tied to 4'hB. Expected:
  - bnn_weights = A53C, bnn_bias = 0FF0, bnn_input = 9;
  - trig high for exactly 2 cycles;
  - out_data = B;
  - infer_count = 1.
- Backpressure: hold out_ready = 0 for 10 cycles after out_valid. Expected:
  - out_valid and out_data stay stable;
  - in_ready = 0 throughout;
  - a byte driven during this time is not consumed;
  - raising out_ready yields a 1-cycle handshake, then in_ready = 1.
- Gapped input: insert random in_valid gaps between bytes. Expected:
  - bnn_* stay at the previous frame's values until byte 4 is accepted;
  - trig never rises early.
- Abort after byte 2, then send a full new frame 11 22 33 44 05. Expected: bnn_weights = 1122, bnn_bias = 3344, bnn_input = 5, with no mixing of the partial frame. Repeat with abort asserted in DONE: out_valid drops the next cycle and infer_count is unchanged by the abort.
- Async reset asserted in SETTLE: all outputs go to their reset values immediately. The first frame after release completes normally.
- SETTLE_CYCLES = 1 and 255. Expected: trig width equals the parameter. Also run 3 back-to-back frames with out_ready = 1 and check a period of SETTLE_CYCLES + 6 cycles.
